csi2_tx_vc_scheduler: RTL and testbench
=======================================

# csi2_tx_vc_scheduler

Round-robin scheduler that shares the single CSI-2 TX global-operation datapath between four upstream packet sources in the 4-to-1 aggregator. It owns the D-PHY HS/LP sequencing handshake: clock-lane HS request, lead time, data-lane HS request and wait for ready. It then forwards one complete packet, applies data trail time, and either re-arbitrates with the clock held in HS or drops the clock lane back to LP after an idle timeout. It drives the `dphy_pkt`, `clk_hs_en` and `d_hs_en` inputs of `USERNAME_tx_global_operation`.

## Interface
Parameters:
- `DATA_WIDTH`, 8, per-lane byte width; matches `PP_DATA_WIDTH`.
- `T_CLK_PRE`, 4, cycles from `clk_hs_en_o` rise to `d_hs_en_o` rise; legal range 1–255.
- `T_D_TRAIL`, 8, cycles of data-lane LP gap after the last beat; legal range 1–255.
- `T_CLK_IDLE`, 16, idle cycles in CLK_HOLD before the clock lane drops to LP; legal range 1–255.
- `CONT_CLK`, 0, 1 = clock lane never leaves HS after first entry.

Ports:
- `core_clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `req_i`  in  4  per-source packet pending; held high until that source's last beat is accepted.
- `pkt_i`  in  4*4*DATA_WIDTH  per-source lane-packed beat; source k occupies bits [k*4*DATA_WIDTH +: 4*DATA_WIDTH].
- `pkt_vld_i`  in  4  beat valid.
- `pkt_last_i`  in  4  last beat of packet; qualified by valid.
- `pkt_rdy_o`  out  4  beat accepted; one-hot or zero.
- `gnt_o`  out  4  one-hot grant, high from HS_REQ through the accepted last beat.
- `clk_hs_en_o`  out  1  clock-lane HS request.
- `d_hs_en_o`  out  1  data-lane HS request.
- `d_hs_rdy_i`  in  1  data lanes in HS and ready.
- `dphy_pkten_o`  out  1  beat valid to the global operation.
- `dphy_pkt_o`  out  4*DATA_WIDTH  beat to the global operation.
- `active_ch_o`  out  2  index of the current or last winner.
- `busy_o`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, CLK_LEAD, HS_REQ, XFER, TRAIL, CLK_HOLD.
- IDLE: all requests off.
  - On any `req_i`: latch the round-robin winner, set `clk_hs_en_o`, go to CLK_LEAD.
- CLK_LEAD: count `T_CLK_PRE` cycles, then go to HS_REQ.
- HS_REQ: `d_hs_en_o`=1 and `gnt_o`=winner.
  - Wait on `d_hs_rdy_i`; no timeout.
  - On the cycle `d_hs_rdy_i`=1, go to XFER.
- XFER: `pkt_rdy_o[win]`=1.
  - Each cycle, `pkt_vld_i[win]` and the winner's slice are registered onto `dphy_pkten_o`/`dphy_pkt_o`. A vld-low cycle gives `dphy_pkten_o`=0 for that cycle.
  - On an accepted beat with `pkt_last_i[win]`: deassert `d_hs_en_o`, clear `gnt_o`/`pkt_rdy_o`, go to TRAIL.
- TRAIL: count `T_D_TRAIL` cycles, then go to CLK_HOLD.
- CLK_HOLD: `clk_hs_en_o` stays 1.
  - Any request: latch winner, go to HS_REQ. CLK_LEAD is skipped.
  - Else after `T_CLK_IDLE` cycles: if `CONT_CLK`=0, clear `clk_hs_en_o` and go to IDLE; if `CONT_CLK`=1, stay in CLK_HOLD.
- Arbitration:
  - A rotating pointer `ptr` (reset 0) gives priority order ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - On latch, ptr becomes winner+1, modulo 4.
  - Arbitration happens only at the IDLE/CLK_HOLD exit. Requests arriving later wait for the next exit.
  - Winner index drives `active_ch_o`.
- Illegal input: `req_i[win]` dropping before last is ignored; the block keeps waiting for the last beat. Beats on non-granted sources are ignored.
- Counters are 8-bit and load `T_x`-1 on state entry. The state exits when the counter reads 0 (exactly `T_x` cycles in state).

## Timing
- Reset: all outputs 0, state IDLE, ptr 0, counters 0. A reset asserted mid-packet forces this on the next edge; no trail is applied.
- Request to `clk_hs_en_o`: 1 cycle (registered).
- `clk_hs_en_o` rise to `d_hs_en_o` rise: `T_CLK_PRE` cycles.
- `d_hs_rdy_i` high at edge n: `pkt_rdy_o` is high in cycle n+1.
- Data latency: beat accepted at edge m appears on `dphy_pkt_o` after edge m+1.
- Last beat accepted at edge m:
  - `d_hs_en_o` falls after edge m+1, aligned with the last `dphy_pkten_o` cycle.
  - The next `d_hs_en_o` rise comes no earlier than `T_D_TRAIL`+1 cycles later.
- `d_hs_rdy_i` deasserting during XFER has no effect; it is only sampled in HS_REQ.

## Structure
- Shared package `csi2_4to1_pkg`: state enum, `NUM_SRC`=4, counter width 8, `LANE_BUS_W`=4*DATA_WIDTH.
- Sub-module `csi2_rr_arb4`: combinational 4-way round-robin pick from `req` and `ptr`, returning a one-hot winner and its index. The FSM, counters and data register stay in the top module.

## Test plan
- Single request, `T_CLK_PRE`=4, `T_D_TRAIL`=8, `T_CLK_IDLE`=16: `req_i`=0001, `d_hs_rdy_i` 3 cycles after `d_hs_en_o`, 5-beat packet.
  - 4 cycles from `clk_hs_en_o` to `d_hs_en_o`; 5 `dphy_pkten_o` beats equal to the input.
  - `clk_hs_en_o` low 8+16 cycles after the last beat.
- All four request at once, from reset: grant order 0, 1, 2, 3.
  - CLK_LEAD occurs only once; each packet is separated by an 8-cycle TRAIL.
  - `active_ch_o` sequence 0, 1, 2, 3.
- Fairness: source 0 re-requests continuously, source 2 requests once. Order is 0, 2, 0.
- Valid gap: winner drops `pkt_vld_i` for 2 mid-packet cycles. `dphy_pkten_o` low exactly 2 cycles, one cycle delayed; `d_hs_en_o` stays high.
- `CONT_CLK`=1: after the packet and 100 idle cycles, `clk_hs_en_o` is still 1. A new request goes directly to `d_hs_en_o` with no CLK_LEAD.
- Reset asserted in XFER beat 3: next cycle all outputs 0 and state IDLE. The following request is granted to source 0 (ptr reset).

Source files
------------

// File: rtl/csi2_4to1_pkg.sv
// csi2_4to1_pkg: shared constants and state encoding for the
// 4-to-1 CSI-2 TX aggregator (scheduler FSM, arbiter, lane bus).
package csi2_4to1_pkg;

    localparam int NUM_SRC    = 4;
    localparam int NUM_LANE   = 4;
    localparam int CNT_W      = 8;
    localparam int LANE_BUS_W = NUM_LANE * 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_CLK_LEAD = 3'd1;
    localparam state_t ST_HS_REQ   = 3'd2;
    localparam state_t ST_XFER     = 3'd3;
    localparam state_t ST_TRAIL    = 3'd4;
    localparam state_t ST_CLK_HOLD = 3'd5;

    // Lane-packed beat width for a given per-lane byte width.
    function automatic int lane_bus_w(input int dw);
        return (LANE_BUS_W / 8) * dw;
    endfunction

endpackage

// File: rtl/csi2_rr_arb4.sv
// csi2_rr_arb4: combinational 4-way round-robin pick.
// Ports: req (pending sources), ptr (highest-priority index),
// gnt (one-hot winner), idx (winner index), any (some req set).
module csi2_rr_arb4
    import csi2_4to1_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [1:0]         idx,
    output logic               any
);

    // Walk from lowest to highest priority so the
    // highest-priority requester is the last to write.
    always_comb begin
        logic [1:0] k;
        gnt = '0;
        idx = ptr;
        k   = ptr;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            k = ptr + 2'(i);
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/csi2_tx_vc_scheduler.sv
// csi2_tx_vc_scheduler: round-robin share of the CSI-2 TX global
// operation between four sources, with D-PHY HS/LP sequencing.
// Ports: core_clk/reset (sync, active-high); req_i/pkt_i/pkt_vld_i/
// pkt_last_i/pkt_rdy_o/gnt_o per-source side; clk_hs_en_o,
// d_hs_en_o, d_hs_rdy_i lane handshake; dphy_pkten_o/dphy_pkt_o
// beat out; active_ch_o winner index; busy_o not idle.
module csi2_tx_vc_scheduler
    import csi2_4to1_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int T_CLK_PRE  = 4,
    parameter int T_D_TRAIL  = 8,
    parameter int T_CLK_IDLE = 16,
    parameter bit CONT_CLK   = 1'b0
) (
    input  logic                           core_clk,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             req_i,
    input  logic [NUM_SRC*NUM_LANE*DATA_WIDTH-1:0] pkt_i,
    input  logic [NUM_SRC-1:0]             pkt_vld_i,
    input  logic [NUM_SRC-1:0]             pkt_last_i,
    output logic [NUM_SRC-1:0]             pkt_rdy_o,
    output logic [NUM_SRC-1:0]             gnt_o,
    output logic                           clk_hs_en_o,
    output logic                           d_hs_en_o,
    input  logic                           d_hs_rdy_i,
    output logic                           dphy_pkten_o,
    output logic [NUM_LANE*DATA_WIDTH-1:0] dphy_pkt_o,
    output logic [1:0]                     active_ch_o,
    output logic                           busy_o
);

    localparam int LW = lane_bus_w(DATA_WIDTH);
    localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(T_CLK_PRE - 1);
    localparam logic [CNT_W-1:0] TRAIL_LD = CNT_W'(T_D_TRAIL - 1);
    localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(T_CLK_IDLE - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         ptr;
    logic [NUM_SRC-1:0] win;

    logic [NUM_SRC-1:0] arb_gnt;
    logic [1:0]         arb_idx;
    logic               arb_any;
    logic               beat_vld;
    logic               beat_last;
    logic [LW-1:0]      win_beat;

    csi2_rr_arb4 u_arb (
        .req (req_i),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign beat_vld  = |(pkt_vld_i & win);
    assign beat_last = |(pkt_last_i & win);

    always_comb begin
        win_beat = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (win[k]) begin
                win_beat = pkt_i[k*LW +: LW];
            end
        end
    end

    assign gnt_o = (state == ST_HS_REQ || state == ST_XFER)
                 ? win : '0;
    assign pkt_rdy_o = (state == ST_XFER) ? win : '0;
    assign busy_o    = (state != ST_IDLE);

    always_ff @(posedge core_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ptr          <= '0;
            win          <= '0;
            active_ch_o  <= '0;
            clk_hs_en_o  <= 1'b0;
            d_hs_en_o    <= 1'b0;
            dphy_pkten_o <= 1'b0;
            dphy_pkt_o   <= '0;
        end else begin
            dphy_pkten_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        win         <= arb_gnt;
                        active_ch_o <= arb_idx;
                        ptr         <= arb_idx + 2'd1;
                        clk_hs_en_o <= 1'b1;
                        cnt         <= PRE_LD;
                        state       <= ST_CLK_LEAD;
                    end
                end
                ST_CLK_LEAD: begin
                    if (cnt == '0) begin
                        d_hs_en_o <= 1'b1;
                        state     <= ST_HS_REQ;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HS_REQ: begin
                    if (d_hs_rdy_i) begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    dphy_pkten_o <= beat_vld;
                    dphy_pkt_o   <= win_beat;
                    if (beat_vld && beat_last) begin
                        cnt   <= TRAIL_LD;
                        state <= ST_TRAIL;
                    end
                end
                ST_TRAIL: begin
                    // Held one extra cycle past XFER so the lane
                    // stays in HS under the registered last beat.
                    d_hs_en_o <= 1'b0;
                    if (cnt == '0) begin
                        cnt   <= IDLE_LD;
                        state <= ST_CLK_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_CLK_HOLD: begin
                    if (arb_any) begin
                        win         <= arb_gnt;
                        active_ch_o <= arb_idx;
                        ptr         <= arb_idx + 2'd1;
                        d_hs_en_o   <= 1'b1;
                        state       <= ST_HS_REQ;
                    end else if (cnt == '0) begin
                        if (!CONT_CLK) begin
                            clk_hs_en_o <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_tx_vc_scheduler.sv
// tb_csi2_tx_vc_scheduler: directed bench for the VC scheduler,
// one default instance and one continuous-clock instance.
module tb_csi2_tx_vc_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req, vld, last;
    logic [127:0] pkt;
    logic         d_hs_rdy;
    logic         sel;

    logic [3:0]  rdy0, gnt0, rdy1, gnt1;
    logic        clk0, dhs0, pkten0, busy0;
    logic        clk1, dhs1, pkten1, busy1;
    logic [31:0] dpkt0, dpkt1;
    logic [1:0]  ach0, ach1;

    logic [3:0]  m_rdy, m_gnt;
    logic        m_clk, m_dhs, m_pkten, m_busy;
    logic [31:0] m_pkt;
    logic [1:0]  m_ach;

    always #5 clk = ~clk;

    csi2_tx_vc_scheduler #(
        .DATA_WIDTH(8), .T_CLK_PRE(4), .T_D_TRAIL(8),
        .T_CLK_IDLE(16), .CONT_CLK(1'b0)
    ) dut0 (
        .core_clk(clk), .reset(reset), .req_i(req), .pkt_i(pkt),
        .pkt_vld_i(vld), .pkt_last_i(last), .pkt_rdy_o(rdy0),
        .gnt_o(gnt0), .clk_hs_en_o(clk0), .d_hs_en_o(dhs0),
        .d_hs_rdy_i(d_hs_rdy), .dphy_pkten_o(pkten0),
        .dphy_pkt_o(dpkt0), .active_ch_o(ach0), .busy_o(busy0)
    );

    csi2_tx_vc_scheduler #(
        .DATA_WIDTH(8), .T_CLK_PRE(4), .T_D_TRAIL(8),
        .T_CLK_IDLE(16), .CONT_CLK(1'b1)
    ) dut1 (
        .core_clk(clk), .reset(reset), .req_i(req), .pkt_i(pkt),
        .pkt_vld_i(vld), .pkt_last_i(last), .pkt_rdy_o(rdy1),
        .gnt_o(gnt1), .clk_hs_en_o(clk1), .d_hs_en_o(dhs1),
        .d_hs_rdy_i(d_hs_rdy), .dphy_pkten_o(pkten1),
        .dphy_pkt_o(dpkt1), .active_ch_o(ach1), .busy_o(busy1)
    );

    assign m_rdy   = sel ? rdy1   : rdy0;
    assign m_gnt   = sel ? gnt1   : gnt0;
    assign m_clk   = sel ? clk1   : clk0;
    assign m_dhs   = sel ? dhs1   : dhs0;
    assign m_pkten = sel ? pkten1 : pkten0;
    assign m_pkt   = sel ? dpkt1  : dpkt0;
    assign m_ach   = sel ? ach1   : ach0;
    assign m_busy  = sel ? busy1  : busy0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int act[4], len[4], bi[4], rep[4];
    int gat[4], gn[4], gcnt[4], pid[4];
    logic [3:0] acc;
    int dcnt, rdy_dly, gap_cyc;
    logic dhs_s;

    logic p_clk, p_dhs, p_rdyi, p_prdy;
    int n_clk_rise, n_clk_fall, t_clk_rise, t_clk_fall;
    int t_rdyi, t_prdy, bad_oh;
    int q_rise[$], q_rise_ch[$], q_fall[$], q_bcyc[$];
    logic [31:0] q_bdat[$];

    function automatic logic [31:0] word(int k, int p, int b);
        return {4'hA, 4'(k), 8'(p), 8'(b), 8'h5C ^ 8'(b)};
    endfunction

    task automatic check(string tag, logic [63:0] got,
                         logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int k = 0; k < 4; k++) begin
            req[k]  = (act[k] != 0);
            vld[k]  = (act[k] != 0) && (gcnt[k] == 0);
            last[k] = (act[k] != 0) && (bi[k] == len[k] - 1);
            pkt[k*32 +: 32] = (act[k] != 0)
                            ? word(k, pid[k], bi[k]) : 32'hDEADBEEF;
        end
    endtask

    task automatic clear_mon();
        n_clk_rise = 0; n_clk_fall = 0;
        t_clk_rise = -1; t_clk_fall = -1;
        t_rdyi = -1; t_prdy = -1; bad_oh = 0;
        q_rise.delete(); q_rise_ch.delete(); q_fall.delete();
        q_bcyc.delete(); q_bdat.delete();
    endtask

    task automatic step();
        @(negedge clk);
        acc = m_rdy & vld;
        if (m_clk && !p_clk) begin
            n_clk_rise++; t_clk_rise = cyc;
        end
        if (!m_clk && p_clk) begin
            n_clk_fall++; t_clk_fall = cyc;
        end
        if (m_dhs && !p_dhs) begin
            q_rise.push_back(cyc); q_rise_ch.push_back(int'(m_ach));
        end
        if (!m_dhs && p_dhs) q_fall.push_back(cyc);
        if (d_hs_rdy && !p_rdyi) t_rdyi = cyc;
        if ((|m_rdy) && !p_prdy) t_prdy = cyc;
        if (m_pkten) begin
            q_bcyc.push_back(cyc); q_bdat.push_back(m_pkt);
        end
        if ($countones(m_rdy) > 1 || $countones(m_gnt) > 1 ||
            (m_rdy & ~m_gnt) != 4'd0) bad_oh++;
        p_clk = m_clk; p_dhs = m_dhs;
        p_rdyi = d_hs_rdy; p_prdy = |m_rdy;
        dhs_s = m_dhs;
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (act[k] != 0) begin
                if (acc[k]) begin
                    if (bi[k] == len[k] - 1) begin
                        if (rep[k] > 0) begin
                            rep[k]--; bi[k] = 0; pid[k]++;
                        end else begin
                            act[k] = 0;
                        end
                    end else begin
                        if (bi[k] == gat[k]) begin
                            gcnt[k] = gn[k]; gap_cyc = cyc;
                        end
                        bi[k]++;
                    end
                end else if (gcnt[k] > 0) begin
                    gcnt[k]--;
                end
            end
        end
        if (dhs_s) dcnt++;
        else dcnt = 0;
        d_hs_rdy = dhs_s && (dcnt >= rdy_dly);
        drive_srcs();
    endtask

    task automatic kill_srcs();
        for (int k = 0; k < 4; k++) begin
            act[k] = 0; bi[k] = 0; gcnt[k] = 0; len[k] = 1;
        end
        dcnt = 0; d_hs_rdy = 1'b0;
        drive_srcs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        kill_srcs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic start(int k, int l, int r, int ga, int g);
        act[k] = 1; len[k] = l; rep[k] = r;
        gat[k] = ga; gn[k] = g; gcnt[k] = 0; bi[k] = 0;
        pid[k]++;
        drive_srcs();
    endtask

    task automatic run(int budget, bit need_idle);
        int n;
        n = 0;
        while (n < budget &&
               ((act[0] | act[1] | act[2] | act[3]) != 0 ||
                (need_idle && m_busy))) begin
            step();
            n++;
        end
        if (n >= budget) check("timeout", 64'(1), 64'(0));
        step();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int c0, r, gf;
        int exp3[4];
        sel = 1'b0; reset = 1'b1; rdy_dly = 3; gap_cyc = 0;
        p_clk = 0; p_dhs = 0; p_rdyi = 0; p_prdy = 0; dhs_s = 0;
        for (int k = 0; k < 4; k++) begin
            pid[k] = 0; rep[k] = 0; gat[k] = -1; gn[k] = 0;
        end
        kill_srcs();
        clear_mon();
        do_reset();

        check("rst_out0", 64'({rdy0, gnt0, clk0, dhs0, pkten0,
                               dpkt0, ach0, busy0}), 64'(0));
        check("rst_out1", 64'({rdy1, gnt1, clk1, dhs1, pkten1,
                               dpkt1, ach1, busy1}), 64'(0));

        // single 5-beat packet from source 0
        clear_mon();
        start(0, 5, 0, -1, 0);
        c0 = cyc;
        run(300, 1'b1);
        check("t1_req2clk", 64'(t_clk_rise - c0), 64'(1));
        check("t1_nrise", 64'(q_rise.size()), 64'(1));
        check("t1_lead", 64'(q_rise[0] - t_clk_rise), 64'(4));
        check("t1_rdy2xfer", 64'(t_prdy - t_rdyi), 64'(1));
        check("t1_nbeat", 64'(q_bdat.size()), 64'(5));
        for (int b = 0; b < 5; b++)
            check("t1_data", 64'(q_bdat[b]), 64'(word(0, pid[0], b)));
        check("t1_contig", 64'(q_bcyc[4] - q_bcyc[0]), 64'(4));
        check("t1_dfall", 64'(q_fall[0] - q_bcyc[4]), 64'(1));
        check("t1_clkoff", 64'(t_clk_fall - q_bcyc[4]), 64'(24));
        check("t1_onehot", 64'(bad_oh), 64'(0));

        // all four at once
        do_reset();
        clear_mon();
        for (int k = 0; k < 4; k++) start(k, 3, 0, -1, 0);
        run(600, 1'b1);
        check("t2_nclklead", 64'(n_clk_rise), 64'(1));
        check("t2_npkt", 64'(q_rise.size()), 64'(4));
        check("t2_nbeat", 64'(q_bdat.size()), 64'(12));
        for (int i = 0; i < 4; i++) begin
            check("t2_ach", 64'(q_rise_ch[i]), 64'(i));
            check("t2_src", 64'(q_bdat[3*i][27:24]), 64'(i));
        end
        for (int i = 0; i < 3; i++)
            check("t2_trail", 64'(q_rise[i+1] - q_fall[i]), 64'(8));
        check("t2_onehot", 64'(bad_oh), 64'(0));

        // fairness: source 0 keeps requesting, source 2 once
        do_reset();
        clear_mon();
        start(0, 2, 2, -1, 0);
        start(2, 2, 0, -1, 0);
        run(600, 1'b1);
        exp3[0] = 0; exp3[1] = 2; exp3[2] = 0; exp3[3] = 0;
        check("t3_npkt", 64'(q_rise_ch.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            check("t3_order", 64'(q_rise_ch[i]), 64'(exp3[i]));

        // two-cycle valid gap mid-packet
        do_reset();
        clear_mon();
        start(0, 6, 0, 2, 2);
        run(300, 1'b1);
        check("t4_nbeat", 64'(q_bdat.size()), 64'(6));
        check("t4_lowcyc", 64'(q_bcyc[5] - q_bcyc[0] + 1 - 6), 64'(2));
        gf = -1;
        for (int i = 0; i < 5; i++)
            if (gf < 0 && q_bcyc[i+1] != q_bcyc[i] + 1)
                gf = q_bcyc[i] + 1;
        check("t4_gapdly", 64'(gf), 64'(gap_cyc + 1));
        check("t4_nfall", 64'(q_fall.size()), 64'(1));
        check("t4_dfall", 64'(q_fall[0] - q_bcyc[5]), 64'(1));
        for (int b = 0; b < 6; b++)
            check("t4_data", 64'(q_bdat[b]), 64'(word(0, pid[0], b)));

        // reset in the middle of a packet
        do_reset();
        clear_mon();
        start(0, 6, 0, -1, 0);
        r = 0;
        while (bi[0] < 3 && r < 200) begin
            step();
            r++;
        end
        if (r >= 200) check("t6_wait", 64'(1), 64'(0));
        check("t6_inxfer", 64'(rdy0), 64'(4'b0001));
        reset = 1'b1;
        kill_srcs();
        step();
        check("t6_rst_out", 64'({rdy0, gnt0, clk0, dhs0, pkten0,
                                 dpkt0, ach0, busy0}), 64'(0));
        reset = 1'b0;
        step();
        clear_mon();
        start(0, 2, 0, -1, 0);
        start(1, 2, 0, -1, 0);
        run(400, 1'b1);
        check("t6_npkt", 64'(q_rise_ch.size()), 64'(2));
        check("t6_first", 64'(q_rise_ch[0]), 64'(0));
        check("t6_second", 64'(q_rise_ch[1]), 64'(1));

        // continuous clock instance
        sel = 1'b1;
        do_reset();
        p_clk = 0; p_dhs = 0; p_rdyi = 0; p_prdy = 0;
        clear_mon();
        start(0, 3, 0, -1, 0);
        run(300, 1'b0);
        repeat (100) step();
        check("t5_clk_hold", 64'(clk1), 64'(1));
        check("t5_busy", 64'(busy1), 64'(1));
        check("t5_nfall", 64'(n_clk_fall), 64'(0));
        clear_mon();
        start(0, 2, 0, -1, 0);
        r = cyc;
        run(300, 1'b0);
        check("t5_nrise", 64'(q_rise.size()), 64'(1));
        check("t5_nolead", 64'(q_rise[0] - r), 64'(1));
        check("t5_noclkre", 64'(n_clk_rise), 64'(0));
        check("t5_nbeat", 64'(q_bdat.size()), 64'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
